regfile_write_queue: RTL and testbench

//   Writeback buffer directly upstream of the 32x32 register file write port.

---
 rtl/regfile_write_queue_if.sv | 39 +++
 rtl/regfile_write_queue.sv | 90 +++++++++
 tb/tb_regfile_write_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_queue_if.sv
// Handshake and register-file bus between writeback producers, decode and the write queue.
// The slave modport is the queue side; the master modport drives requests and observes status.
interface regfile_write_queue_if #(
    parameter int AW = 2
);
    logic          MemValid;
    logic          MemReady;
    logic [4:0]    MemReg;
    logic [31:0]   MemData;
    logic          AluValid;
    logic          AluReady;
    logic [4:0]    AluReg;
    logic [31:0]   AluData;
    logic          DrainEn;
    logic          RegWrite;
    logic [4:0]    WriteRegister;
    logic [31:0]   WriteData;
    logic [4:0]    ReadRegister1;
    logic [4:0]    ReadRegister2;
    logic          Pending1;
    logic          Pending2;
    logic [AW:0]   Count;
    logic          Full;
    logic          Empty;

    modport slave (
        input  MemValid, MemReg, MemData, AluValid, AluReg, AluData,
        input  DrainEn, ReadRegister1, ReadRegister2,
        output MemReady, AluReady, RegWrite, WriteRegister, WriteData,
        output Pending1, Pending2, Count, Full, Empty
    );

    modport master (
        output MemValid, MemReg, MemData, AluValid, AluReg, AluData,
        output DrainEn, ReadRegister1, ReadRegister2,
        input  MemReady, AluReady, RegWrite, WriteRegister, WriteData,
        input  Pending1, Pending2, Count, Full, Empty
    );
endinterface

// File: rtl/regfile_write_queue.sv
// In-order writeback FIFO in front of the 32x32 register file write port, fed by the load
// and ALU paths, drained one entry per cycle, with RAW pending flags for two decode read ports.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    regfile_write_queue_if.slave  bus
);
    logic [4:0]    entry_reg   [DEPTH];
    logic [31:0]   entry_data  [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    logic [AW:0]   free;
    logic          mem_fire, alu_fire;
    logic          mem_push, alu_push;
    logic          empty;
    logic          pop;
    logic [AW-1:0] alu_slot;
    logic [AW:0]   push_count;

    // Space comes from registered state only, so a same-edge pop never admits an extra request.
    assign free     = (AW+1)'(DEPTH) - count;
    assign empty    = (count == '0);

    assign bus.MemReady = Rst_n && (free >= (AW+1)'(1));
    assign bus.AluReady = Rst_n && (bus.MemValid ? (free >= (AW+1)'(2)) : (free >= (AW+1)'(1)));

    assign mem_fire = bus.MemValid && bus.MemReady;
    assign alu_fire = bus.AluValid && bus.AluReady;
    assign mem_push = mem_fire && (bus.MemReg != 5'd0);
    assign alu_push = alu_fire && (bus.AluReg != 5'd0);

    // The load entry goes ahead of the ALU entry when both land on the same edge.
    assign alu_slot   = tail + AW'(mem_push);
    assign push_count = (AW+1)'(mem_push) + (AW+1)'(alu_push);

    assign pop               = bus.DrainEn && !empty;
    assign bus.RegWrite      = pop;
    assign bus.WriteRegister = empty ? 5'd0  : entry_reg[head];
    assign bus.WriteData     = empty ? 32'd0 : entry_data[head];
    assign bus.Count         = count;
    assign bus.Empty         = empty;
    assign bus.Full          = (count == (AW+1)'(DEPTH));

    always_comb begin
        bus.Pending1 = 1'b0;
        bus.Pending2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_reg[i] == bus.ReadRegister1))
                bus.Pending1 = 1'b1;
            if (entry_valid[i] && (entry_reg[i] == bus.ReadRegister2))
                bus.Pending2 = 1'b1;
        end
        if (bus.ReadRegister1 == 5'd0) bus.Pending1 = 1'b0;
        if (bus.ReadRegister2 == 5'd0) bus.Pending2 = 1'b0;
    end

    // NOTE: only control state and valid bits are reset; payload storage is qualified by
    // entry_valid, so leaving it unreset keeps it a plain register array.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (pop) begin
                entry_valid[head] <= 1'b0;
                head              <= head + AW'(1);
            end
            if (mem_push) begin
                entry_valid[tail] <= 1'b1;
                entry_reg[tail]   <= bus.MemReg;
                entry_data[tail]  <= bus.MemData;
            end
            if (alu_push) begin
                entry_valid[alu_slot] <= 1'b1;
                entry_reg[alu_slot]   <= bus.AluReg;
                entry_data[alu_slot]  <= bus.AluData;
            end
            tail  <= tail + AW'(push_count);
            count <= count + push_count - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: stimulus pushes expected register-file writes into
// a scoreboard queue that a negedge monitor pops whenever the DUT asserts RegWrite.
module tb_regfile_write_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic Clk = 1'b0;
    logic Rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    wr_t  expected_q [$];

    regfile_write_queue_if #(.AW(AW)) bus ();

    regfile_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.MemValid = 1'b0;
        bus.MemReg   = 5'd0;
        bus.MemData  = 32'd0;
        bus.AluValid = 1'b0;
        bus.AluReg   = 5'd0;
        bus.AluData  = 32'd0;
    endtask

    task automatic drive_mem(input logic [4:0] rd, input logic [31:0] data, input bit expect_write);
        bus.MemValid = 1'b1;
        bus.MemReg   = rd;
        bus.MemData  = data;
        if (expect_write) expected_q.push_back('{rd: rd, data: data});
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data, input bit expect_write);
        bus.AluValid = 1'b1;
        bus.AluReg   = rd;
        bus.AluData  = data;
        if (expect_write) expected_q.push_back('{rd: rd, data: data});
    endtask

    // Each negedge with RegWrite high is one register-file write at the following posedge.
    always @(negedge Clk) begin
        if (Rst_n === 1'b1 && bus.RegWrite === 1'b1) begin
            if (expected_q.size() == 0) begin
                check("unexpected_write_reg", {27'd0, bus.WriteRegister}, 32'd0);
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t exp_wr;
                exp_wr = expected_q.pop_front();
                check("write_reg", {27'd0, bus.WriteRegister}, {27'd0, exp_wr.rd});
                check("write_data", bus.WriteData, exp_wr.data);
            end
        end
    end

    initial begin
        idle_inputs();
        bus.DrainEn       = 1'b0;
        bus.ReadRegister1 = 5'd0;
        bus.ReadRegister2 = 5'd0;
        Rst_n             = 1'b0;

        // Reset held for two edges
        step();
        step();
        check("rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        check("rst_count", {29'd0, bus.Count}, 32'd0);
        check("rst_empty", {31'd0, bus.Empty}, 32'd1);
        check("rst_full", {31'd0, bus.Full}, 32'd0);
        check("rst_mem_ready", {31'd0, bus.MemReady}, 32'd0);
        check("rst_alu_ready", {31'd0, bus.AluReady}, 32'd0);
        Rst_n = 1'b1;
        #1;
        check("rel_mem_ready", {31'd0, bus.MemReady}, 32'd1);
        check("rel_alu_ready", {31'd0, bus.AluReady}, 32'd1);

        // Single ALU write with one-cycle latency to the register file
        bus.DrainEn = 1'b1;
        drive_alu(5'd5, 32'hDEADBEEF, 1'b1);
        step();
        idle_inputs();
        bus.ReadRegister1 = 5'd5;
        #1;
        check("single_regwrite", {31'd0, bus.RegWrite}, 32'd1);
        check("single_pending1", {31'd0, bus.Pending1}, 32'd1);
        check("single_count", {29'd0, bus.Count}, 32'd1);
        step();
        check("single_empty", {31'd0, bus.Empty}, 32'd1);
        check("single_pending1_clear", {31'd0, bus.Pending1}, 32'd0);

        // Simultaneous Mem and ALU requests into an empty queue
        drive_mem(5'd8, 32'h1111, 1'b1);
        drive_alu(5'd9, 32'h2222, 1'b1);
        #1;
        check("dual_alu_ready", {31'd0, bus.AluReady}, 32'd1);
        step();
        idle_inputs();
        check("dual_count", {29'd0, bus.Count}, 32'd2);
        step();
        step();
        check("dual_empty", {31'd0, bus.Empty}, 32'd1);

        // Fill to DEPTH with draining held off, then release
        bus.DrainEn = 1'b0;
        drive_mem(5'd1, 32'h0000_0101, 1'b1);
        drive_alu(5'd2, 32'h0000_0202, 1'b1);
        step();
        drive_mem(5'd3, 32'h0000_0303, 1'b1);
        drive_alu(5'd4, 32'h0000_0404, 1'b1);
        step();
        idle_inputs();
        bus.ReadRegister1 = 5'd1;
        bus.ReadRegister2 = 5'd4;
        #1;
        check("full_count", {29'd0, bus.Count}, 32'd4);
        check("full_flag", {31'd0, bus.Full}, 32'd1);
        check("full_mem_ready", {31'd0, bus.MemReady}, 32'd0);
        check("full_alu_ready", {31'd0, bus.AluReady}, 32'd0);
        check("full_pending1", {31'd0, bus.Pending1}, 32'd1);
        check("full_pending2", {31'd0, bus.Pending2}, 32'd1);
        check("full_no_write", {31'd0, bus.RegWrite}, 32'd0);
        bus.DrainEn = 1'b1;
        repeat (4) step();
        check("drain_empty", {31'd0, bus.Empty}, 32'd1);
        check("drain_pending2", {31'd0, bus.Pending2}, 32'd0);

        // Destination register 0 is accepted and dropped
        bus.ReadRegister1 = 5'd0;
        drive_alu(5'd0, 32'hFFFFFFFF, 1'b0);
        #1;
        check("r0_alu_ready", {31'd0, bus.AluReady}, 32'd1);
        step();
        idle_inputs();
        check("r0_count", {29'd0, bus.Count}, 32'd0);
        check("r0_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        check("r0_pending1", {31'd0, bus.Pending1}, 32'd0);

        // Duplicate destinations drain in order
        drive_mem(5'd7, 32'h0000_000A, 1'b1);
        drive_alu(5'd7, 32'h0000_000B, 1'b1);
        step();
        idle_inputs();
        check("dup_count", {29'd0, bus.Count}, 32'd2);
        step();
        step();
        check("dup_empty", {31'd0, bus.Empty}, 32'd1);

        // Three entries queued, one free slot, then reset discards them
        bus.DrainEn = 1'b0;
        drive_mem(5'd10, 32'h0000_0A0A, 1'b0);
        drive_alu(5'd11, 32'h0000_0B0B, 1'b0);
        step();
        idle_inputs();
        drive_mem(5'd12, 32'h0000_0C0C, 1'b0);
        step();
        idle_inputs();
        check("three_count", {29'd0, bus.Count}, 32'd3);
        bus.MemValid = 1'b1;
        bus.AluValid = 1'b1;
        #1;
        check("one_free_mem_ready", {31'd0, bus.MemReady}, 32'd1);
        check("one_free_alu_ready", {31'd0, bus.AluReady}, 32'd0);
        idle_inputs();
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        check("midrst_count", {29'd0, bus.Count}, 32'd0);
        check("midrst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        bus.DrainEn = 1'b1;
        repeat (4) step();
        check("midrst_still_empty", {31'd0, bus.Empty}, 32'd1);

        // Every expected write must have been observed
        check("scoreboard_drained", expected_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
